ram_port_arbiter: RTL and testbench

//  Shares one single-port synchronous RAM between the IF stage (instruction fetch) and the MEM stage
//  (data load/store). Sequences each access through a small FSM, holds RAM controls stable for the RAM

---
 rtl/ram_port_arbiter_pkg.sv | 25 ++
 rtl/ram_port_arbiter_if.sv | 39 +++
 rtl/ram_arb_pick.sv | 28 ++
 rtl/ram_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_ram_port_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// Shared widths and encodings for the IF/MEM single-port RAM arbiter.
// Consumed by ram_port_arbiter, ram_arb_pick and ram_port_arbiter_if.
package ram_port_arbiter_pkg;

   localparam int ADDR_BUS    = 32;
   localparam int DATA_BUS    = 32;
   localparam int MEM_SEL_BUS = 4;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_BUSY = 2'd1,
      ARB_DONE = 2'd2
   } arb_state_e;

   typedef enum logic {
      ARB_OWNER_IF   = 1'b0,
      ARB_OWNER_DATA = 1'b1
   } arb_owner_e;

   // Fetch addresses are byte addresses; the RAM only ever sees word addresses.
   function automatic logic [ADDR_BUS-1:0] word_align(input logic [ADDR_BUS-1:0] addr);
      return addr & {{(ADDR_BUS-2){1'b1}}, 2'b00};
   endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Request/response and RAM-side bundle of the IF/MEM RAM port arbiter.
// Handshake: a requester raises if_req/d_en with stable address/data and holds them until its
// one-cycle *_ready pulse (rdata valid in that cycle); ready is never back-pressured.
interface ram_port_arbiter_if;
   import ram_port_arbiter_pkg::*;

   logic                   if_req;
   logic [ADDR_BUS-1:0]    if_addr;
   logic [DATA_BUS-1:0]    if_rdata;
   logic                   if_ready;

   logic                   d_en;
   logic [MEM_SEL_BUS-1:0] d_we;
   logic [ADDR_BUS-1:0]    d_addr;
   logic [DATA_BUS-1:0]    d_wdata;
   logic [DATA_BUS-1:0]    d_rdata;
   logic                   d_ready;

   logic                   ram_en;
   logic [MEM_SEL_BUS-1:0] ram_we;
   logic [ADDR_BUS-1:0]    ram_addr;
   logic [DATA_BUS-1:0]    ram_wdata;
   logic [DATA_BUS-1:0]    ram_rdata;

   logic                   stall_req;

   modport slave (
      input  if_req, if_addr, d_en, d_we, d_addr, d_wdata, ram_rdata,
      output if_rdata, if_ready, d_rdata, d_ready,
      output ram_en, ram_we, ram_addr, ram_wdata, stall_req
   );

   modport master (
      output if_req, if_addr, d_en, d_we, d_addr, d_wdata, ram_rdata,
      input  if_rdata, if_ready, d_rdata, d_ready,
      input  ram_en, ram_we, ram_addr, ram_wdata, stall_req
   );

endinterface

// File: rtl/ram_arb_pick.sv
// Combinational owner selection for the RAM port: data wins unless the fetch side is starving.
// The fairness input exists only when RAM_ARB_FAIRNESS_EN is defined.
module ram_arb_pick
   import ram_port_arbiter_pkg::*;
(
   input  logic       d_en,
   input  logic       if_req,
`ifdef RAM_ARB_FAIRNESS_EN
   input  logic       fair_hit,
`endif
   output logic       valid,
   output arb_owner_e owner
);

   always_comb begin
      valid = d_en | if_req;
      owner = ARB_OWNER_IF;
      if (d_en) begin
         owner = ARB_OWNER_DATA;
      end
`ifdef RAM_ARB_FAIRNESS_EN
      if (fair_hit) begin
         owner = ARB_OWNER_IF;
      end
`endif
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and the MEM stage.
// Optional fetch starvation relief is enabled by defining RAM_ARB_FAIRNESS_EN.
module ram_port_arbiter
   import ram_port_arbiter_pkg::*;
#(
   parameter int RAM_LATENCY = 1,
   parameter int FAIR_LIMIT  = 4
) (
   input  logic              clk,
   input  logic              rst,
   ram_port_arbiter_if.slave bus,
   output arb_state_e        state
);

   if (RAM_LATENCY < 1 || RAM_LATENCY > 7 || FAIR_LIMIT < 1 || FAIR_LIMIT > 7) begin : g_param_check
      $error("ram_port_arbiter: RAM_LATENCY and FAIR_LIMIT must be in 1..7");
   end

   arb_state_e             next_state;
   arb_owner_e             owner;
   arb_owner_e             pick_owner;
   logic                   pick_valid;
   logic [2:0]             cnt;
   logic [ADDR_BUS-1:0]    addr_q;
   logic [MEM_SEL_BUS-1:0] we_q;
   logic [DATA_BUS-1:0]    wdata_q;
   logic [DATA_BUS-1:0]    if_rdata_q;
   logic [DATA_BUS-1:0]    d_rdata_q;

`ifdef RAM_ARB_FAIRNESS_EN
   logic [2:0] fair_cnt;
   logic       fair_hit;

   assign fair_hit = bus.if_req && (fair_cnt == 3'(FAIR_LIMIT));

   // Counts back-to-back data grants that left a fetch waiting; any fetch grant or idle fetch clears it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fair_cnt <= '0;
      end else if (state == ARB_IDLE) begin
         if (!bus.if_req || (pick_valid && pick_owner == ARB_OWNER_IF)) begin
            fair_cnt <= '0;
         end else if (bus.d_en) begin
            fair_cnt <= fair_cnt + 3'd1;
         end
      end
   end
`endif

   ram_arb_pick u_pick (
      .d_en     (bus.d_en),
      .if_req   (bus.if_req),
`ifdef RAM_ARB_FAIRNESS_EN
      .fair_hit (fair_hit),
`endif
      .valid    (pick_valid),
      .owner    (pick_owner)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ARB_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state    = state;
      bus.ram_en    = 1'b0;
      bus.ram_we    = '0;
      bus.ram_addr  = '0;
      bus.ram_wdata = '0;
      bus.if_ready  = 1'b0;
      bus.d_ready   = 1'b0;
      case (state)
         ARB_IDLE: begin
            if (pick_valid) begin
               next_state = ARB_BUSY;
            end
         end
         ARB_BUSY: begin
            bus.ram_en    = 1'b1;
            bus.ram_we    = we_q;
            bus.ram_addr  = addr_q;
            bus.ram_wdata = wdata_q;
            if (cnt == 3'd1) begin
               next_state = ARB_DONE;
            end
         end
         ARB_DONE: begin
            bus.if_ready = (owner == ARB_OWNER_IF);
            bus.d_ready  = (owner == ARB_OWNER_DATA);
            next_state   = ARB_IDLE;
         end
         default: begin
            next_state = ARB_IDLE;
         end
      endcase
   end

   // Request fields are captured once in IDLE so the RAM sees stable controls for the whole access.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner      <= ARB_OWNER_IF;
         cnt        <= '0;
         addr_q     <= '0;
         we_q       <= '0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (pick_valid) begin
                  owner <= pick_owner;
                  cnt   <= 3'(RAM_LATENCY);
                  if (pick_owner == ARB_OWNER_DATA) begin
                     addr_q  <= bus.d_addr;
                     we_q    <= bus.d_we;
                     wdata_q <= bus.d_wdata;
                  end else begin
                     addr_q  <= word_align(bus.if_addr);
                     we_q    <= '0;
                     wdata_q <= '0;
                  end
               end
            end
            ARB_BUSY: begin
               cnt <= cnt - 3'd1;
               if (cnt == 3'd1) begin
                  if (owner == ARB_OWNER_IF) begin
                     if_rdata_q <= bus.ram_rdata;
                  end else if (we_q == '0) begin
                     d_rdata_q <= bus.ram_rdata;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.if_rdata  = if_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.stall_req = rst & ((bus.d_en & ~bus.d_ready) | (bus.if_req & ~bus.if_ready));

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: a latency-1 instance for most traffic and a
// latency-3 instance for the multi-cycle hold; RAM_ARB_FAIRNESS_EN selects expected grant order.
module tb_ram_port_arbiter;
   import ram_port_arbiter_pkg::*;

   localparam int LAT_A = 1;
   localparam int LAT_B = 3;

   typedef struct {
      logic        is_data;
      logic [3:0]  we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_ram_addr;
      logic [3:0]  exp_ram_we;
      logic [31:0] exp_rdata;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   ram_port_arbiter_if bus_a ();
   ram_port_arbiter_if bus_b ();
   arb_state_e state_a;
   arb_state_e state_b;

   ram_port_arbiter #(.RAM_LATENCY(LAT_A), .FAIR_LIMIT(4)) dut_a (
      .clk(clk), .rst(rst), .bus(bus_a), .state(state_a)
   );
   ram_port_arbiter #(.RAM_LATENCY(LAT_B), .FAIR_LIMIT(4)) dut_b (
      .clk(clk), .rst(rst), .bus(bus_b), .state(state_b)
   );

   // RAM models: data is only valid on the LAT-th consecutive ram_en cycle, garbage otherwise.
   logic [31:0] mem_a [256];
   logic [31:0] mem_b [256];
   bit init_a = 1'b0;
   bit init_b = 1'b0;
   int en_cnt_a = 0;
   int en_cnt_b = 0;

   always @(posedge clk) begin
      if (!init_a) begin
         for (int i = 0; i < 256; i++) mem_a[i] = 32'hC0DE_0000 | 32'(i);
         init_a = 1'b1;
      end else if (bus_a.ram_en) begin
         for (int b = 0; b < 4; b++)
            if (bus_a.ram_we[b]) mem_a[bus_a.ram_addr[9:2]][8*b +: 8] = bus_a.ram_wdata[8*b +: 8];
      end
      en_cnt_a <= bus_a.ram_en ? en_cnt_a + 1 : 0;
   end

   always @(posedge clk) begin
      if (!init_b) begin
         for (int i = 0; i < 256; i++) mem_b[i] = 32'hC0DE_0000 | 32'(i);
         init_b = 1'b1;
      end else if (bus_b.ram_en) begin
         for (int b = 0; b < 4; b++)
            if (bus_b.ram_we[b]) mem_b[bus_b.ram_addr[9:2]][8*b +: 8] = bus_b.ram_wdata[8*b +: 8];
      end
      en_cnt_b <= bus_b.ram_en ? en_cnt_b + 1 : 0;
   end

   assign bus_a.ram_rdata = (bus_a.ram_en && en_cnt_a == LAT_A - 1) ? mem_a[bus_a.ram_addr[9:2]] : 32'hDEAD_BEEF;
   assign bus_b.ram_rdata = (bus_b.ram_en && en_cnt_b == LAT_B - 1) ? mem_b[bus_b.ram_addr[9:2]] : 32'hDEAD_BEEF;

   int checks = 0;
   int failures = 0;
   logic [31:0] exp_q [$];
   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   task automatic sb_check(input string name, input logic [31:0] act);
      logic [31:0] e;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s actual=0x%08h expected=<nothing queued>", name, act);
      end else begin
         e = exp_q.pop_front();
         check(name, act, e);
      end
   endtask

   task automatic idle_inputs_a();
      bus_a.if_req = 1'b0; bus_a.if_addr = '0;
      bus_a.d_en = 1'b0; bus_a.d_we = '0; bus_a.d_addr = '0; bus_a.d_wdata = '0;
   endtask

   task automatic idle_inputs_b();
      bus_b.if_req = 1'b0; bus_b.if_addr = '0;
      bus_b.d_en = 1'b0; bus_b.d_we = '0; bus_b.d_addr = '0; bus_b.d_wdata = '0;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      bit seen;
      int k;
      @(posedge clk); #1;
      bus_a.d_en    = v.is_data;
      bus_a.if_req  = ~v.is_data;
      bus_a.d_we    = v.we;
      bus_a.d_wdata = v.wdata;
      bus_a.d_addr  = v.is_data ? v.addr : 32'h80;
      bus_a.if_addr = v.is_data ? 32'h0 : v.addr;
      exp_q.push_back(v.exp_rdata);
      seen = 1'b0;
      k = 0;
      while (!seen && k < LAT_A + 6) begin
         @(negedge clk);
         if (k == 1) begin
            check($sformatf("vec%0d_ram_en", idx), 32'(bus_a.ram_en), 32'd1);
            check($sformatf("vec%0d_ram_addr", idx), bus_a.ram_addr, v.exp_ram_addr);
            check($sformatf("vec%0d_ram_we", idx), 32'(bus_a.ram_we), 32'(v.exp_ram_we));
         end
         if (v.is_data ? bus_a.d_ready : bus_a.if_ready) begin
            seen = 1'b1;
            check($sformatf("vec%0d_latency", idx), k, LAT_A + 1);
            check($sformatf("vec%0d_stall_at_ready", idx), 32'(bus_a.stall_req), 32'd0);
            sb_check($sformatf("vec%0d_rdata", idx), v.is_data ? bus_a.d_rdata : bus_a.if_rdata);
         end else if (k <= LAT_A) begin
            check($sformatf("vec%0d_stall_pending", idx), 32'(bus_a.stall_req), 32'd1);
         end
         k++;
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL vec%0d_timeout actual=no_ready required=ready_by_cycle_%0d", idx, LAT_A + 1);
         exp_q.delete();
      end
      @(posedge clk); #1;
      idle_inputs_a();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=still_running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int d_cyc;
      int i_cyc;
      int en_cycles;
      int done;
      bit addr_ok;
      bit any_ready;
      bit if_seen;

      vecs[0] = '{1'b0, 4'h0, 32'h0000_0106, 32'h0,          32'h0000_0104, 4'h0, 32'hC0DE_0041};
      vecs[1] = '{1'b1, 4'h4, 32'h0000_0020, 32'h00AB_0000,  32'h0000_0020, 4'h4, 32'h0000_0000};
      vecs[2] = '{1'b1, 4'h0, 32'h0000_0020, 32'h0,          32'h0000_0020, 4'h0, 32'hC0AB_0008};
      vecs[3] = '{1'b1, 4'hF, 32'h0000_0044, 32'h1234_5678,  32'h0000_0044, 4'hF, 32'hC0AB_0008};
      vecs[4] = '{1'b0, 4'h0, 32'h0000_0044, 32'h0,          32'h0000_0044, 4'h0, 32'h1234_5678};
      vecs[5] = '{1'b1, 4'h1, 32'h0000_0044, 32'h0000_00EE,  32'h0000_0044, 4'h1, 32'hC0AB_0008};
      vecs[6] = '{1'b1, 4'h0, 32'h0000_0044, 32'h0,          32'h0000_0044, 4'h0, 32'h1234_56EE};
      vecs[7] = '{1'b0, 4'hF, 32'h0000_003F, 32'hFFFF_FFFF,  32'h0000_003C, 4'h0, 32'hC0DE_000F};

      idle_inputs_a();
      idle_inputs_b();

      // Reset state
      repeat (3) @(negedge clk);
      check("reset_state", 32'(state_a), 32'(ARB_IDLE));
      check("reset_ram_en", 32'(bus_a.ram_en), 32'd0);
      check("reset_ram_we", 32'(bus_a.ram_we), 32'd0);
      check("reset_ram_addr", bus_a.ram_addr, 32'd0);
      check("reset_ram_wdata", bus_a.ram_wdata, 32'd0);
      check("reset_ready", 32'({bus_a.if_ready, bus_a.d_ready}), 32'd0);
      check("reset_if_rdata", bus_a.if_rdata, 32'd0);
      check("reset_d_rdata", bus_a.d_rdata, 32'd0);
      check("reset_stall", 32'(bus_a.stall_req), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;

      for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

      check("store_byte2_only", mem_a[8], 32'hC0AB_0008);
      check("store_merge_word", mem_a[17], 32'h1234_56EE);
      check("store_neighbour_untouched", mem_a[9], 32'hC0DE_0009);
      check("d_rdata_held_over_fetch", bus_a.d_rdata, 32'h1234_56EE);

      // Collision: data first, fetch waits one full access
      @(posedge clk); #1;
      bus_a.d_en = 1'b1; bus_a.d_we = 4'h0; bus_a.d_addr = 32'h44;
      bus_a.if_req = 1'b1; bus_a.if_addr = 32'h104;
      exp_q.push_back(32'h1234_56EE);
      exp_q.push_back(32'hC0DE_0041);
      d_cyc = -1;
      i_cyc = -1;
      for (int k = 0; k < 12 && i_cyc < 0; k++) begin
         @(negedge clk);
         if (k == 3) check("collide_stall_if_waiting", 32'(bus_a.stall_req), 32'd1);
         if (bus_a.d_ready) begin d_cyc = k; sb_check("collide_d_rdata", bus_a.d_rdata); end
         if (bus_a.if_ready) begin i_cyc = k; sb_check("collide_if_rdata", bus_a.if_rdata); end
         @(posedge clk); #1;
         if (d_cyc >= 0) bus_a.d_en = 1'b0;
         if (i_cyc >= 0) bus_a.if_req = 1'b0;
      end
      check("collide_d_cycle", d_cyc, 32'd2);
      check("collide_if_cycle", i_cyc, 32'd5);
      idle_inputs_a();
      exp_q.delete();

      // Reset in the middle of a fetch
      @(posedge clk); #1;
      bus_a.if_req = 1'b1; bus_a.if_addr = 32'h3C;
      @(posedge clk); #1;
      check("rst_pre_state_busy", 32'(state_a), 32'(ARB_BUSY));
      check("rst_pre_ram_en", 32'(bus_a.ram_en), 32'd1);
      rst = 1'b0;
      #1;
      check("rst_state_idle", 32'(state_a), 32'(ARB_IDLE));
      check("rst_ram_en", 32'(bus_a.ram_en), 32'd0);
      check("rst_ram_addr", bus_a.ram_addr, 32'd0);
      check("rst_if_rdata", bus_a.if_rdata, 32'd0);
      check("rst_d_rdata", bus_a.d_rdata, 32'd0);
      any_ready = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if (bus_a.if_ready || bus_a.d_ready) any_ready = 1'b1;
      end
      check("rst_no_ready", 32'(any_ready), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      exp_q.push_back(32'hC0DE_000F);
      i_cyc = -1;
      for (int k = 0; k < 10 && i_cyc < 0; k++) begin
         @(negedge clk);
         if (bus_a.if_ready) begin i_cyc = k; sb_check("rst_reserve_if_rdata", bus_a.if_rdata); end
         @(posedge clk); #1;
         if (i_cyc >= 0) bus_a.if_req = 1'b0;
      end
      check("rst_reserve_latency", i_cyc, 32'd2);
      idle_inputs_a();
      exp_q.delete();

      // Latency-3 load on the second instance
      @(posedge clk); #1;
      bus_b.d_en = 1'b1; bus_b.d_we = 4'h0; bus_b.d_addr = 32'h40;
      exp_q.push_back(32'hC0DE_0010);
      en_cycles = 0;
      d_cyc = -1;
      addr_ok = 1'b1;
      for (int k = 0; k < 12 && d_cyc < 0; k++) begin
         @(negedge clk);
         if (bus_b.ram_en) begin
            en_cycles++;
            if (bus_b.ram_addr !== 32'h40) addr_ok = 1'b0;
         end
         if (bus_b.d_ready) begin d_cyc = k; sb_check("lat3_d_rdata", bus_b.d_rdata); end
         @(posedge clk); #1;
         if (d_cyc >= 0) bus_b.d_en = 1'b0;
      end
      check("lat3_ram_en_cycles", en_cycles, 32'd3);
      check("lat3_addr_stable", 32'(addr_ok), 32'd1);
      check("lat3_ready_cycle", d_cyc, 32'd4);
      idle_inputs_b();
      exp_q.delete();

      // Continuous data traffic with a waiting fetch: grant order (2 = data, 1 = fetch)
      @(posedge clk); #1;
      bus_a.d_en = 1'b1; bus_a.d_we = 4'h0; bus_a.d_addr = 32'h20;
      bus_a.if_req = 1'b1; bus_a.if_addr = 32'h0;
`ifdef RAM_ARB_FAIRNESS_EN
      for (int g = 0; g < 4; g++) exp_q.push_back(32'd2);
      exp_q.push_back(32'd1);
`else
      for (int g = 0; g < 5; g++) exp_q.push_back(32'd2);
`endif
      done = 0;
      if_seen = 1'b0;
      for (int k = 0; k < 40 && done < 5; k++) begin
         @(negedge clk);
         if (bus_a.d_ready || bus_a.if_ready) begin
            sb_check($sformatf("fair_grant%0d_owner", done), {30'd0, bus_a.d_ready, bus_a.if_ready});
            if (bus_a.if_ready) if_seen = 1'b1;
            done++;
         end
         @(posedge clk); #1;
         if (if_seen) bus_a.if_req = 1'b0;
      end
      check("fair_completions", done, 32'd5);
      bus_a.d_en = 1'b0;
`ifndef RAM_ARB_FAIRNESS_EN
      i_cyc = -1;
      for (int k = 0; k < 10 && i_cyc < 0; k++) begin
         @(negedge clk);
         if (bus_a.if_ready) i_cyc = k;
         @(posedge clk); #1;
         if (i_cyc >= 0) bus_a.if_req = 1'b0;
      end
      check("fair_if_served_after_data_stops", i_cyc, 32'd2);
`endif
      idle_inputs_a();
      exp_q.delete();

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
